// File: rtl/md_ctrl_pkg.sv
// Shared constants for the multiply/divide sequencer: op encodings, default
// latencies, FSM states and op-class helpers.
package md_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_CYCLES = 5;
   localparam int unsigned MD_DIV_CYCLES  = 10;

   // Ops that occupy the unit for a countdown (mult/multu/div/divu).
   function automatic logic md_is_long(input logic [2:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// EX/ID-side bundle for the md sequencer. md_flush exists only when
// MD_FLUSH_EN is defined.
interface md_ctrl_if;

   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] md_rs;
   logic [31:0] md_rt;
   logic        md_use_ID;
`ifdef MD_FLUSH_EN
   logic        md_flush;
`endif
   logic        md_busy;
   logic        md_stall;
   logic [31:0] md_hi;
   logic [31:0] md_lo;

   modport master (
      output md_valid, md_op, md_rs, md_rt, md_use_ID,
`ifdef MD_FLUSH_EN
      output md_flush,
`endif
      input  md_busy, md_stall, md_hi, md_lo
   );

   modport slave (
      input  md_valid, md_op, md_rs, md_rt, md_use_ID,
`ifdef MD_FLUSH_EN
      input  md_flush,
`endif
      output md_busy, md_stall, md_hi, md_lo
   );

endinterface

// File: rtl/md_alu.sv
// Combinational 64-bit mult/div result generator ({HI, LO} packing).
// Divide by zero yields zero and raises md_div_zero so the caller can skip commit.
module md_alu
   import md_ctrl_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] md_rs,
   input  logic [31:0] md_rt,
   output logic [63:0] md_res,
   output logic        md_div_zero
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;

   always_comb begin
      md_div_zero = (md_rt == '0);
      prod_s = $signed({{32{md_rs[31]}}, md_rs}) * $signed({{32{md_rt[31]}}, md_rt});
      prod_u = {32'b0, md_rs} * {32'b0, md_rt};
      quot_s = '0;
      rem_s  = '0;
      quot_u = '0;
      rem_u  = '0;
      // SV signed / and % truncate toward zero, remainder follows the dividend.
      if (!md_div_zero) begin
         quot_s = $signed(md_rs) / $signed(md_rt);
         rem_s  = $signed(md_rs) % $signed(md_rt);
         quot_u = md_rs / md_rt;
         rem_u  = md_rs % md_rt;
      end
      case (md_op_e'(md_op))
         MD_MULT:  md_res = prod_s;
         MD_MULTU: md_res = prod_u;
         MD_DIV:   md_res = {rem_s, quot_s};
         MD_DIVU:  md_res = {rem_u, quot_u};
         default:  md_res = '0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer owning HI/LO; models mult/div latency with a
// countdown and requests ID stalls. Optional flush input: MD_FLUSH_EN.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
)
(
   input logic      clk,
   input logic      rst,
   md_ctrl_if.slave md
);

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   md_state_e   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0] hi, hi_n, lo, lo_n;
   logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
   logic        pend_ok, pend_ok_n;
   logic        accept, start;
   logic [63:0] alu_res;
   logic        div_zero;

   md_alu u_alu (
      .md_op       (md.md_op),
      .md_rs       (md.md_rs),
      .md_rt       (md.md_rt),
      .md_res      (alu_res),
      .md_div_zero (div_zero)
   );

`ifdef MD_FLUSH_EN
   assign accept = md.md_valid && (state == MD_IDLE) && !md.md_flush;
`else
   assign accept = md.md_valid && (state == MD_IDLE);
`endif
   assign start = accept && md_is_long(md.md_op);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_ok <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_ok <= pend_ok_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_ok_n = pend_ok;
      case (state)
         MD_IDLE: begin
            if (start) begin
               state_n   = MD_BUSY;
               cnt_n     = md_is_div(md.md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               pend_hi_n = alu_res[63:32];
               pend_lo_n = alu_res[31:0];
               pend_ok_n = !(md_is_div(md.md_op) && div_zero);
            end else if (accept && (md.md_op == MD_MTHI)) begin
               hi_n = md.md_rs;
            end else if (accept && (md.md_op == MD_MTLO)) begin
               lo_n = md.md_rs;
            end
         end
         MD_BUSY: begin
            // Ops arriving here are ignored; the stall keeps them out of EX.
            if (cnt <= CW'(1)) begin
               state_n   = MD_IDLE;
               cnt_n     = '0;
               pend_ok_n = 1'b0;
               if (pend_ok) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = MD_IDLE;
      endcase
   end

   assign md.md_busy  = (state == MD_BUSY);
   assign md.md_stall = md.md_use_ID && (start || (state == MD_BUSY));
   assign md.md_hi    = hi;
   assign md.md_lo    = lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus queues expected commits, a monitor
// checks busy length, held HI/LO while busy, and committed HI/LO.
module tb_md_ctrl;
   import md_ctrl_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] hold_hi;
      logic [31:0] hold_lo;
      int unsigned cycles;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t q[$];

   md_ctrl_if bus();

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk (clk),
      .rst (rst),
      .md  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = op;
      bus.md_rs    = rs;
      bus.md_rt    = rt;
   endtask

   task automatic release_in();
      @(posedge clk);
      #1;
      bus.md_valid = 1'b0;
      bus.md_op    = MD_NONE;
`ifdef MD_FLUSH_EN
      bus.md_flush = 1'b0;
`endif
   endtask

   task automatic wait_idle(input string name);
      int unsigned n;
      n = 0;
      while (bus.md_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, " idle timeout"}, 32'(bus.md_busy), 32'd0);
      @(negedge clk);
   endtask

   // Monitor: counts busy cycles and checks each commit against the queue.
   initial begin
      int unsigned cnt;
      logic        prev;
      exp_t        e;
      cnt  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (prev && q.size() > 0) begin
               e = q.pop_front();
               chk({e.name, " cycles before abort"}, cnt, e.cycles);
            end
            cnt  = 0;
            prev = 1'b0;
         end else if (bus.md_busy) begin
            cnt++;
            if (q.size() > 0) begin
               chk({q[0].name, " held hi"}, bus.md_hi, q[0].hold_hi);
               chk({q[0].name, " held lo"}, bus.md_lo, q[0].hold_lo);
            end else begin
               chk("busy without op", 32'd1, 32'd0);
            end
            prev = 1'b1;
         end else begin
            if (prev) begin
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk({e.name, " busy cycles"}, cnt, e.cycles);
                  chk({e.name, " hi"}, bus.md_hi, e.hi);
                  chk({e.name, " lo"}, bus.md_lo, e.lo);
               end else begin
                  chk("unexpected commit", 32'd1, 32'd0);
               end
            end
            cnt  = 0;
            prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.md_valid  = 1'b0;
      bus.md_op     = MD_NONE;
      bus.md_rs     = '0;
      bus.md_rt     = '0;
      bus.md_use_ID = 1'b0;
`ifdef MD_FLUSH_EN
      bus.md_flush  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.md_busy), 32'd0);
      chk("reset hi", bus.md_hi, 32'h0);
      chk("reset lo", bus.md_lo, 32'h0);
      rst = 1'b0;

      drive(MD_MTHI, 32'h12345678, 32'h0); release_in();
      chk("mthi", bus.md_hi, 32'h12345678);
      drive(MD_MTLO, 32'h9ABCDEF0, 32'h0); release_in();
      chk("mtlo", bus.md_lo, 32'h9ABCDEF0);

      // mult -2 * 3 with a dependent md instruction in ID
      q.push_back(exp_t'{"mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h12345678, 32'h9ABCDEF0, 5});
      bus.md_use_ID = 1'b1;
      drive(MD_MULT, 32'hFFFFFFFE, 32'd3);
      #1 chk("stall start cycle", 32'(bus.md_stall), 32'd1);
      release_in();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall while busy", 32'(bus.md_stall), 32'd1);
      end
      @(negedge clk);
      chk("stall after idle", 32'(bus.md_stall), 32'd0);
      bus.md_use_ID = 1'b0;

      // divu 100 / 7 with nothing in ID
      q.push_back(exp_t'{"divu", 32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFA, 10});
      drive(MD_DIVU, 32'd100, 32'd7);
      #1 chk("no stall start cycle", 32'(bus.md_stall), 32'd0);
      release_in();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("no stall while busy", 32'(bus.md_stall), 32'd0);
      end
      wait_idle("divu");

      q.push_back(exp_t'{"div", 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd2, 32'd14, 10});
      drive(MD_DIV, 32'hFFFFFFF9, 32'd2); release_in();
      wait_idle("div");

      // divide by zero keeps preloaded HI/LO
      drive(MD_MTHI, 32'h11, 32'h0); release_in();
      drive(MD_MTLO, 32'h22, 32'h0); release_in();
      chk("preload hi", bus.md_hi, 32'h11);
      chk("preload lo", bus.md_lo, 32'h22);
      q.push_back(exp_t'{"div0", 32'h11, 32'h22, 32'h11, 32'h22, 10});
      drive(MD_DIV, 32'd5, 32'd0); release_in();
      wait_idle("div0");

      // ops arriving while busy are ignored
      q.push_back(exp_t'{"multu", 32'h1, 32'hFFFFFFFE, 32'h11, 32'h22, 5});
      drive(MD_MULTU, 32'hFFFFFFFF, 32'd2); release_in();
      drive(MD_MTHI, 32'hDEADBEEF, 32'h0); release_in();
      drive(MD_MULT, 32'd7, 32'd7); release_in();
      wait_idle("multu");

      drive(MD_NONE, 32'd1234, 32'd5); release_in();
      bus.md_use_ID = 1'b1;
      @(negedge clk);
      chk("op none busy", 32'(bus.md_busy), 32'd0);
      chk("op none stall", 32'(bus.md_stall), 32'd0);
      chk("op none hi", bus.md_hi, 32'h1);
      chk("op none lo", bus.md_lo, 32'hFFFFFFFE);
      bus.md_use_ID = 1'b0;

      // asynchronous reset at busy cycle 3
      q.push_back(exp_t'{"mult rst", 32'h0, 32'h0, 32'h1, 32'hFFFFFFFE, 3});
      drive(MD_MULT, 32'd5, 32'd5); release_in();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", 32'(bus.md_busy), 32'd0);
      chk("async rst hi", bus.md_hi, 32'h0);
      chk("async rst lo", bus.md_lo, 32'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("post rst busy", 32'(bus.md_busy), 32'd0);
      chk("post rst hi", bus.md_hi, 32'h0);
      chk("post rst lo", bus.md_lo, 32'h0);

`ifdef MD_FLUSH_EN
      drive(MD_MTHI, 32'hAB, 32'h0);
      bus.md_flush = 1'b1;
      release_in();
      chk("flushed mthi", bus.md_hi, 32'h0);
      drive(MD_MULT, 32'd3, 32'd3);
      bus.md_flush = 1'b1;
      release_in();
      repeat (3) @(negedge clk);
      chk("flushed mult busy", 32'(bus.md_busy), 32'd0);
      chk("flushed mult lo", bus.md_lo, 32'h0);
      q.push_back(exp_t'{"mult flush busy", 32'h0, 32'd12, 32'h0, 32'h0, 5});
      drive(MD_MULT, 32'd3, 32'd4); release_in();
      @(negedge clk);
      bus.md_flush = 1'b1;
      @(negedge clk);
      bus.md_flush = 1'b0;
      wait_idle("mult flush busy");
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
